// File: rtl/at_hazard_scoreboard_pkg.sv
// Shared encodings, scoreboard entry type and select priority encoders for the
// MIPS hazard scoreboard.
package at_hazard_scoreboard_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b01;
  localparam logic [1:0] RES_DM   = 2'b10;
  localparam logic [1:0] RES_PC   = 2'b11;

  localparam logic [1:0] MD_OP_NONE = 2'b00;
  localparam logic [1:0] MD_OP_MULT = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_HILO = 2'b11;

  localparam int unsigned TUSE_D = 0;
  localparam int unsigned TUSE_E = 1;
  localparam int unsigned TUSE_M = 2;

  localparam int unsigned STAGE_E    = 1;
  // Width of the padded match/ready vectors; STAGES must not exceed this.
  localparam int unsigned MAX_STAGES = 8;

  typedef struct packed {
    logic       valid;
    logic [4:0] a3;
    logic [1:0] tnew;
  } sb_entry_t;

  function automatic logic [1:0] tuse_of(input logic [2:0] onehot);
    if (onehot[TUSE_D]) return 2'd0;
    else if (onehot[TUSE_E]) return 2'd1;
    else return 2'd2;
  endfunction

  // Bit k-1 describes stage k. Scanning oldest to youngest lets the youngest match win.
  function automatic int unsigned youngest_sel(input logic [MAX_STAGES-1:0] match,
                                               input logic [MAX_STAGES-1:0] ready);
    youngest_sel = 0;
    for (int unsigned k = MAX_STAGES; k > 0; k--) begin
      if (match[k-1]) youngest_sel = ready[k-1] ? k : 0;
    end
  endfunction

endpackage

// File: rtl/at_hazard_scoreboard_entry.sv
// One scoreboard stage: registers the upstream entry, ageing its tnew by one.
module at_sb_entry
  import at_hazard_scoreboard_pkg::*;
#(
  parameter bit DECREMENT = 1'b1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_flush,
  input  sb_entry_t i_ent,
  output sb_entry_t o_ent
);

  sb_entry_t r_ent;
  sb_entry_t w_next;

  always_comb begin
    w_next = i_ent;
    if (DECREMENT && (i_ent.tnew != 2'd0)) w_next.tnew = i_ent.tnew - 2'd1;
    if (i_flush) w_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ent <= '0;
    else          r_ent <= w_next;
  end

  assign o_ent = r_ent;

endmodule

// File: rtl/at_hazard_scoreboard.sv
// Shift-register hazard scoreboard: D-stage stall, D/E forwarding selects and
// HI/LO busy interlock.
module at_hazard_scoreboard
  import at_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned TNEW_ALU    = 1,
  parameter int unsigned TNEW_DM     = 2,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned SEL_W       = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [2:0]       d_tuse_rt,
  input  logic [1:0]       d_res,
  input  logic [4:0]       d_a3,
  input  logic [1:0]       d_md_op,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic [SEL_W-1:0] e_fwd_rs_sel,
  output logic [SEL_W-1:0] e_fwd_rt_sel,
  output logic             md_busy
);

  localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MD_MAX + 1);

  sb_entry_t w_d_ent;
  sb_entry_t w_ent [STAGES];

  logic                  w_admit, w_stall_data, w_stall_md;
  logic                  w_rs_used, w_rt_used;
  logic [1:0]            w_tuse_rs, w_tuse_rt;
  logic [MAX_STAGES-1:0] w_match_rs, w_match_rt, w_ready;
  logic [MAX_STAGES-1:0] w_ematch_rs, w_ematch_rt, w_eready;
  logic [SEL_W-1:0]      w_e_rs_sel, w_e_rt_sel;
  logic [CNT_W-1:0]      w_md_cnt_d;

  logic [CNT_W-1:0]      r_md_cnt;
  logic                  r_e_md_start, r_e_md_div;
  logic [SEL_W-1:0]      r_e_fwd_rs_sel, r_e_fwd_rt_sel;

  assign w_admit = d_valid & ~stall & ~flush;

  always_comb begin
    w_d_ent = '0;
    if (w_admit && (d_res != RES_NONE) && (d_a3 != 5'd0)) begin
      w_d_ent.valid = 1'b1;
      w_d_ent.a3    = d_a3;
      unique case (d_res)
        RES_ALU: w_d_ent.tnew = 2'(TNEW_ALU);
        RES_DM:  w_d_ent.tnew = 2'(TNEW_DM);
        default: w_d_ent.tnew = 2'd0;
      endcase
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_entry
    if (g == STAGE_E - 1) begin : g_first
      at_sb_entry #(.DECREMENT(1'b0)) u_entry (
        .clk    (clk),
        .reset_n(reset_n),
        .i_flush(flush),
        .i_ent  (w_d_ent),
        .o_ent  (w_ent[g])
      );
    end else begin : g_next
      at_sb_entry #(.DECREMENT(1'b1)) u_entry (
        .clk    (clk),
        .reset_n(reset_n),
        .i_flush(flush),
        .i_ent  (w_ent[g-1]),
        .o_ent  (w_ent[g])
      );
    end
  end

  assign w_rs_used = |d_tuse_rs;
  assign w_rt_used = |d_tuse_rt;
  assign w_tuse_rs = tuse_of({1'b0, d_tuse_rs});
  assign w_tuse_rt = tuse_of(d_tuse_rt);

  always_comb begin
    w_stall_data = 1'b0;
    w_match_rs   = '0;
    w_match_rt   = '0;
    w_ready      = '0;
    w_ematch_rs  = '0;
    w_ematch_rt  = '0;
    w_eready     = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_match_rs[k] = w_rs_used && w_ent[k].valid && (w_ent[k].a3 == d_rs) && (d_rs != 5'd0);
      w_match_rt[k] = w_rt_used && w_ent[k].valid && (w_ent[k].a3 == d_rt) && (d_rt != 5'd0);
      w_ready[k]    = (w_ent[k].tnew == 2'd0);
      if (w_match_rs[k] && (w_ent[k].tnew > w_tuse_rs)) w_stall_data = 1'b1;
      if (w_match_rt[k] && (w_ent[k].tnew > w_tuse_rt)) w_stall_data = 1'b1;
      // E selects look at where each entry lands after this edge.
      if (k + 1 < STAGES) begin
        w_ematch_rs[k+1] = w_match_rs[k];
        w_ematch_rt[k+1] = w_match_rt[k];
        w_eready[k+1]    = (w_ent[k].tnew <= 2'd1);
      end
    end
  end

  assign fwd_rs_sel = SEL_W'(youngest_sel(w_match_rs, w_ready));
  assign fwd_rt_sel = SEL_W'(youngest_sel(w_match_rt, w_ready));
  assign w_e_rs_sel = SEL_W'(youngest_sel(w_ematch_rs, w_eready));
  assign w_e_rt_sel = SEL_W'(youngest_sel(w_ematch_rt, w_eready));

  assign md_busy    = (r_md_cnt != '0);
  assign w_stall_md = (d_md_op != MD_OP_NONE) && (md_busy || r_e_md_start);
  assign stall      = d_valid & (w_stall_data | w_stall_md);

  // Counter loads as the MD op leaves E; flush does not cancel a started HI/LO op.
  always_comb begin
    w_md_cnt_d = r_md_cnt;
    if (r_e_md_start)        w_md_cnt_d = r_e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (r_md_cnt != '0) w_md_cnt_d = r_md_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt       <= '0;
      r_e_md_start   <= 1'b0;
      r_e_md_div     <= 1'b0;
      r_e_fwd_rs_sel <= '0;
      r_e_fwd_rt_sel <= '0;
    end else begin
      r_md_cnt       <= w_md_cnt_d;
      r_e_md_start   <= w_admit && ((d_md_op == MD_OP_MULT) || (d_md_op == MD_OP_DIV));
      r_e_md_div     <= w_admit && (d_md_op == MD_OP_DIV);
      r_e_fwd_rs_sel <= w_admit ? w_e_rs_sel : '0;
      r_e_fwd_rt_sel <= w_admit ? w_e_rt_sel : '0;
    end
  end

  assign e_fwd_rs_sel = r_e_fwd_rs_sel;
  assign e_fwd_rt_sel = r_e_fwd_rt_sel;

endmodule

// File: doc/at_hazard_scoreboard.md
# at_hazard_scoreboard

Sequential hazard scoreboard for the 5-stage MIPS pipeline, parametrised in post-decode stage count and result latencies. It consumes per-instruction Tuse/Tnew-class/A3 fields produced by the D-stage decoder and tracks every in-flight writer in a shift-register scoreboard. From that state it generates the D-stage stall, forwarding selects for D- and E-stage readers, and the multiply/divide busy interlock. It sits beside the D/E pipeline registers and replaces ad-hoc per-stage comparators.

## Interface
- STAGES, 3, post-D stages that carry a writer (1=E … STAGES=W)
- TNEW_ALU, 1, Tnew at E entry for ALU-class results
- TNEW_DM, 2, Tnew at E entry for DM-class results (loads, mfc0)
- MULT_CYCLES, 5, HI/LO busy cycles for mult/multu
- DIV_CYCLES, 10, HI/LO busy cycles for div/divu
- SEL_W, $clog2(STAGES+1), forwarding select width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  5 each  source register addresses (A1/A2)
- d_tuse_rs  in  2  one-hot: [0] use in D, [1] use in E; 00 = unused
- d_tuse_rt  in  3  one-hot: [0] D, [1] E, [2] M; 000 = unused
- d_res  in  2  00 none, 01 ALU, 10 DM, 11 PC
- d_a3  in  5  destination register (A3)
- d_md_op  in  2  00 none, 01 mult-class, 10 div-class, 11 HI/LO access (mfhi/mflo/mthi/mtlo)
- flush  in  1  exception/eret flush of all post-D stages
- stall  out  1  hold PC and F/D, insert bubble into E
- fwd_rs_sel, fwd_rt_sel  out  SEL_W each  D-reader source: 0 = register file, k = stage k output
- e_fwd_rs_sel, e_fwd_rt_sel  out  SEL_W each  registered selects for the instruction now in E (0 or 2..STAGES)
- md_busy  out  1  HI/LO unit busy

## Operation
- Scoreboard entry per stage k: valid, a3, tnew (2 bits, saturating). Entry written only if d_res≠00 and d_a3≠0; otherwise valid=0.
- Advance every cycle: entry k+1 ← entry k with tnew=max(tnew−1,0); entry 1 ← D fields if d_valid & ~stall, else bubble (valid=0). Entry STAGES drops off.
- Tnew at E entry: PC 0, ALU TNEW_ALU, DM TNEW_DM.
- Match_k(src): valid_k & a3_k==src & src≠0.
- Tuse value: index of set one-hot bit; unused source never stalls or forwards.
- stall_data: any source with Tuse t and any k with Match_k & tnew_k > t.
- fwd select for D readers: smallest k with Match_k; if tnew_k==0 → k, else 0 (younger match shadows older ones).
- e_fwd_*_sel: computed at the same edge the instruction enters E, against entries that will be 2..STAGES, same youngest-match rule; 0 for bubbles.
- MD: busy counter loads MULT_CYCLES/DIV_CYCLES when an mult/div-class instruction enters E; decrements to 0. md_busy = counter≠0. stall_md: d_valid & d_md_op≠00 & (md_busy | entry 1 is an MD start).
- stall = d_valid & (stall_data | stall_md).
- flush: all entries valid=0 next edge, D instruction not admitted; MD counter unaffected (HI/LO commit already started).

## Timing
- Reset: all entries invalid, tnew 0, MD counter 0; stall=0, all selects 0, md_busy=0.
- stall and fwd_* are combinational from scoreboard state plus D inputs, same cycle.
- e_fwd_* registered: valid one cycle after admission, held until next advance.
- Load-use (lw then dependent E-reader): exactly 1 stall cycle; dependent D-reader (beq): 2 stall cycles.
- flush and stall simultaneous: flush wins, bubble enters E.
- Reset mid-operation clears everything asynchronously; MD op in flight is lost.
- MD counter reload while busy (back-to-back start cannot occur: second start stalls).

## Structure
- Shared package: RES_* class encodings, MD_OP_* encodings, TUSE one-hot bit positions, STAGE_E=1 constant.
- One sub-module: at_sb_entry (single stage entry register with tnew decrement, flush clear), instantiated STAGES times via generate.
- Select priority encoders as functions in the package.

## Test plan
- addu $3 then addu $4,$3,$5 back-to-back -> stall=0, e_fwd_rs_sel=2 on dependent's E cycle.
- lw $2 then beq $2,$0 -> stall=1 for 2 cycles, then fwd_rs_sel=0 (register file via W write-through, STAGES=3) or 3.
- jal then jr $31 next -> stall=0, fwd_rs_sel=1 (PC class Tnew 0).
- div then mflo -> stall held DIV_CYCLES+1 cycles, md_busy falls after 10 cycles.
- lw $2, flush same cycle dependent in D -> no stall next cycle, selects 0.
- Writer to $0 followed by reader of $0 -> stall=0, selects 0.
